// File: rtl/assay_pkg.sv
// Shared types and constants for the assay stage sequencer.
package assay_pkg;

    localparam int DIL_LEVELS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        MIX,
        READ,
        DONE,
        ERR
    } seq_state_e;

endpackage

// File: rtl/assay_stage_sequencer_stage_timer.sv
// Loadable down-counter. It flags the last cycle of an interval that was loaded with N.
module stage_timer #(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          expired_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of 1 marks the final cycle, so a load of N spans exactly N cycles.
    assign expired_o = (count_q == CW'(1));

endmodule

// File: rtl/assay_stage_sequencer.sv
// Steps the serial-dilution tree one stage at a time: pressure request, fill, mix, then read.
module assay_stage_sequencer
    import assay_pkg::*;
#(
    parameter int DIL_LEVELS  = DIL_LEVELS_DEFAULT,
    parameter int CW          = 16,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CW-1:0]         cfg_fill_i,
    input  logic [CW-1:0]         cfg_mix_i,
    input  logic                  press_ack_i,
    output logic                  press_req_o,
    output logic                  sample_vlv_o,
    output logic [DIL_LEVELS-1:0] buffer_vlv_o,
    output logic                  reagent_vlv_o,
    output logic [DIL_LEVELS:0]   mix_en_o,
    output logic                  read_strobe_o,
    output logic [3:0]            stage_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    seq_state_e state_q, state_d;
    logic [3:0] stage_q, stage_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] mix_q, mix_d;
    logic err_q, err_d;

    logic accept_start;
    logic timer_load;
    logic [CW-1:0] timer_val;
    logic timer_expired;

    logic press_req_q, press_req_d;
    logic sample_vlv_q, sample_vlv_d;
    logic [DIL_LEVELS-1:0] buffer_vlv_q, buffer_vlv_d;
    logic reagent_vlv_q, reagent_vlv_d;
    logic [DIL_LEVELS:0] mix_en_q, mix_en_d;
    logic read_strobe_q, read_strobe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    assign accept_start = (state_q == IDLE) && start_i && !abort_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            stage_q <= '0;
            fill_q  <= CW'(1);
            mix_q   <= CW'(1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            fill_q  <= fill_d;
            mix_q   <= mix_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        fill_d  = fill_q;
        mix_d   = mix_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                stage_d = '0;
                if (accept_start) begin
                    state_d = REQ;
                    err_d   = 1'b0;
                    fill_d  = (cfg_fill_i == '0) ? CW'(1) : cfg_fill_i;
                    mix_d   = (cfg_mix_i == '0) ? CW'(1) : cfg_mix_i;
                end
            end
            REQ: begin
                if (press_ack_i) begin
                    state_d = FILL;
                end else if (timer_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            FILL: begin
                if (!press_ack_i) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (timer_expired) begin
                    state_d = MIX;
                end
            end
            MIX: begin
                if (timer_expired) begin
                    if (stage_q == 4'(DIL_LEVELS)) begin
                        state_d = READ;
                    end else begin
                        state_d = REQ;
                        stage_d = stage_q + 4'd1;
                    end
                end
            end
            READ: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            ERR: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase
        if (abort_i) begin
            state_d = IDLE;
            stage_d = '0;
        end
    end

    // One timer serves REQ, FILL and MIX; it is reloaded on every state change.
    always_comb begin
        timer_load = (state_d != state_q);
        timer_val  = CW'(ACK_TIMEOUT);
        case (state_d)
            FILL:    timer_val = fill_q;
            MIX:     timer_val = mix_q;
            default: timer_val = CW'(ACK_TIMEOUT);
        endcase
    end

    stage_timer #(
        .CW(CW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expired_o  (timer_expired)
    );

    // Outputs decode the upcoming state so the registered copies line up with state_q.
    always_comb begin
        press_req_d   = (state_d == REQ) || (state_d == FILL);
        sample_vlv_d  = (state_d == FILL) && (stage_d == 4'd0);
        reagent_vlv_d = (state_d == FILL) && (stage_d == 4'(DIL_LEVELS));
        read_strobe_d = (state_d == READ);
        done_d        = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        buffer_vlv_d  = '0;
        mix_en_d      = '0;
        for (int k = 0; k < DIL_LEVELS; k++) begin
            buffer_vlv_d[k] = (state_d == FILL) && (stage_d == 4'(k));
        end
        for (int k = 0; k <= DIL_LEVELS; k++) begin
            mix_en_d[k] = (state_d == MIX) && (stage_d == 4'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            press_req_q   <= 1'b0;
            sample_vlv_q  <= 1'b0;
            buffer_vlv_q  <= '0;
            reagent_vlv_q <= 1'b0;
            mix_en_q      <= '0;
            read_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            press_req_q   <= press_req_d;
            sample_vlv_q  <= sample_vlv_d;
            buffer_vlv_q  <= buffer_vlv_d;
            reagent_vlv_q <= reagent_vlv_d;
            mix_en_q      <= mix_en_d;
            read_strobe_q <= read_strobe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign press_req_o   = press_req_q;
    assign sample_vlv_o  = sample_vlv_q;
    assign buffer_vlv_o  = buffer_vlv_q;
    assign reagent_vlv_o = reagent_vlv_q;
    assign mix_en_o      = mix_en_q;
    assign read_strobe_o = read_strobe_q;
    assign stage_o       = stage_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_assay_stage_sequencer.sv
// Directed bench for assay_stage_sequencer: full run, timeout, ack loss, abort, edge config, mid-run reset.
module tb_assay_stage_sequencer;

    logic clk = 1'b0;
    logic rstN;
    logic startIn;
    logic abortIn;
    logic [15:0] cfgFill;
    logic [15:0] cfgMix;
    logic pressAck;
    logic pressReq;
    logic sampleVlv;
    logic [7:0] bufferVlv;
    logic reagentVlv;
    logic [8:0] mixEn;
    logic readStrobe;
    logic [3:0] stageOut;
    logic busyOut;
    logic doneOut;
    logic errOut;

    logic [27:0] allOut;
    int checks = 0;
    int failures = 0;
    int doneCount = 0;

    assign allOut = {pressReq, sampleVlv, bufferVlv, reagentVlv, mixEn, readStrobe,
                     stageOut, busyOut, doneOut, errOut};

    always #5 clk = ~clk;

    assay_stage_sequencer #(
        .DIL_LEVELS  (8),
        .CW          (16),
        .ACK_TIMEOUT (1000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .start_i       (startIn),
        .abort_i       (abortIn),
        .cfg_fill_i    (cfgFill),
        .cfg_mix_i     (cfgMix),
        .press_ack_i   (pressAck),
        .press_req_o   (pressReq),
        .sample_vlv_o  (sampleVlv),
        .buffer_vlv_o  (bufferVlv),
        .reagent_vlv_o (reagentVlv),
        .mix_en_o      (mixEn),
        .read_strobe_o (readStrobe),
        .stage_o       (stageOut),
        .busy_o        (busyOut),
        .done_o        (doneOut),
        .err_o         (errOut)
    );

    task automatic applyStimulus(input logic s, input logic a, input logic ack,
                                 input logic [15:0] f, input logic [15:0] m);
        startIn  = s;
        abortIn  = a;
        pressAck = ack;
        cfgFill  = f;
        cfgMix   = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (doneOut === 1'b1) doneCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int st;
        int ph;

        // Reset
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 16'd0, 16'd0);
        tick();
        tick();
        checkOutput("reset_all_zero", 32'(allOut), 32'h0);

        // Full run, fill=3 mix=5, ack tied high
        rstN = 1'b1;
        applyStimulus(1, 0, 1, 16'd3, 16'd5);
        doneCount = 0;
        for (int c = 1; c <= 84; c++) begin
            tick();
            startIn = 1'b0;
            st = (c - 1) / 9;
            ph = (c - 1) % 9;
            checkOutput($sformatf("run_c%0d_sample", c), 32'(sampleVlv), 32'(c >= 2 && c <= 4));
            checkOutput($sformatf("run_c%0d_reagent", c), 32'(reagentVlv), 32'(c >= 74 && c <= 76));
            checkOutput($sformatf("run_c%0d_press", c), 32'(pressReq), 32'(c <= 81 && ph <= 3));
            checkOutput($sformatf("run_c%0d_buffer", c), 32'(bufferVlv),
                        (c <= 81 && ph >= 1 && ph <= 3 && st < 8) ? (32'h1 << st) : 32'h0);
            checkOutput($sformatf("run_c%0d_mix", c), 32'(mixEn),
                        (c <= 81 && ph >= 4) ? (32'h1 << st) : 32'h0);
            checkOutput($sformatf("run_c%0d_stage", c), 32'(stageOut),
                        (c <= 81) ? 32'(st) : ((c <= 83) ? 32'd8 : 32'd0));
            checkOutput($sformatf("run_c%0d_read", c), 32'(readStrobe), 32'(c == 82));
            checkOutput($sformatf("run_c%0d_done", c), 32'(doneOut), 32'(c == 83));
            checkOutput($sformatf("run_c%0d_busy", c), 32'(busyOut), 32'(c <= 83));
            checkOutput($sformatf("run_c%0d_onehot", c), 32'($countones(mixEn) <= 1), 32'h1);
        end
        checkOutput("run_done_count", 32'(doneCount), 32'd1);

        // Pressure timeout with ack held low
        applyStimulus(1, 0, 0, 16'd3, 16'd5);
        tick();
        startIn = 1'b0;
        checkOutput("to_c1_press", 32'(pressReq), 32'h1);
        repeat (999) tick();
        checkOutput("to_c1000_err", 32'(errOut), 32'h0);
        checkOutput("to_c1000_press", 32'(pressReq), 32'h1);
        tick();
        checkOutput("to_c1001_err", 32'(errOut), 32'h1);
        checkOutput("to_c1001_press", 32'(pressReq), 32'h0);
        checkOutput("to_c1001_busy", 32'(busyOut), 32'h1);
        tick();
        checkOutput("to_idle_only_err", 32'(allOut), 32'h1);
        applyStimulus(1, 0, 1, 16'd3, 16'd5);
        tick();
        startIn = 1'b0;
        checkOutput("to_restart_err_clr", 32'(errOut), 32'h0);
        checkOutput("to_restart_busy", 32'(busyOut), 32'h1);
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        checkOutput("to_abort_busy", 32'(busyOut), 32'h0);

        // Ack loss during stage 3 FILL
        doneCount = 0;
        applyStimulus(1, 0, 1, 16'd3, 16'd5);
        tick();
        startIn = 1'b0;
        repeat (29) tick();
        checkOutput("ack_c30_buffer", 32'(bufferVlv), 32'h08);
        checkOutput("ack_c30_stage", 32'(stageOut), 32'd3);
        pressAck = 1'b0;
        tick();
        pressAck = 1'b1;
        checkOutput("ack_c31_buffer", 32'(bufferVlv), 32'h0);
        checkOutput("ack_c31_err", 32'(errOut), 32'h1);
        checkOutput("ack_c31_press", 32'(pressReq), 32'h0);
        repeat (20) tick();
        checkOutput("ack_no_done", 32'(doneCount), 32'd0);
        checkOutput("ack_idle_busy", 32'(busyOut), 32'h0);

        // Abort during stage 5 MIX, then restart
        applyStimulus(1, 0, 1, 16'd3, 16'd5);
        tick();
        startIn = 1'b0;
        checkOutput("ab_c1_err_clr", 32'(errOut), 32'h0);
        repeat (51) tick();
        checkOutput("ab_c52_mix", 32'(mixEn), 32'h020);
        checkOutput("ab_c52_stage", 32'(stageOut), 32'd5);
        doneCount = 0;
        abortIn = 1'b1;
        tick();
        checkOutput("ab_c53_busy", 32'(busyOut), 32'h0);
        checkOutput("ab_c53_stage", 32'(stageOut), 32'd0);
        checkOutput("ab_c53_mix", 32'(mixEn), 32'h0);
        startIn = 1'b1;
        tick();
        checkOutput("ab_start_with_abort", 32'(busyOut), 32'h0);
        checkOutput("ab_no_done", 32'(doneCount), 32'd0);
        applyStimulus(0, 0, 1, 16'd3, 16'd5);
        tick();
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
        checkOutput("rs_c1_busy", 32'(busyOut), 32'h1);
        checkOutput("rs_c1_stage", 32'(stageOut), 32'd0);
        checkOutput("rs_c1_press", 32'(pressReq), 32'h1);
        tick();
        checkOutput("rs_c2_sample", 32'(sampleVlv), 32'h1);
        repeat (3) tick();
        applyStimulus(1, 0, 1, 16'd7, 16'd7);
        tick();
        startIn = 1'b0;
        repeat (4) tick();
        checkOutput("rs_c10_stage", 32'(stageOut), 32'd1);
        checkOutput("rs_c10_press", 32'(pressReq), 32'h1);
        checkOutput("rs_c10_buffer", 32'(bufferVlv), 32'h0);
        tick();
        checkOutput("rs_c11_buffer", 32'(bufferVlv), 32'h02);
        repeat (3) tick();
        checkOutput("rs_c14_mix", 32'(mixEn), 32'h002);
        repeat (5) tick();
        checkOutput("rs_c19_stage", 32'(stageOut), 32'd2);
        repeat (2) tick();
        checkOutput("rs_c21_buffer", 32'(bufferVlv), 32'h04);
        rstN = 1'b0;
        tick();
        checkOutput("midreset_all_zero", 32'(allOut), 32'h0);
        rstN = 1'b1;
        tick();

        // Zero config behaves as one cycle each
        applyStimulus(1, 0, 1, 16'd0, 16'd0);
        tick();
        startIn = 1'b0;
        checkOutput("z_c1_press", 32'(pressReq), 32'h1);
        tick();
        checkOutput("z_c2_sample", 32'(sampleVlv), 32'h1);
        tick();
        checkOutput("z_c3_mix", 32'(mixEn), 32'h001);
        tick();
        checkOutput("z_c4_stage", 32'(stageOut), 32'd1);
        checkOutput("z_c4_press", 32'(pressReq), 32'h1);
        tick();
        checkOutput("z_c5_buffer", 32'(bufferVlv), 32'h02);
        repeat (23) tick();
        checkOutput("z_c28_read", 32'(readStrobe), 32'h1);
        tick();
        checkOutput("z_c29_done", 32'(doneOut), 32'h1);
        tick();
        checkOutput("z_c30_busy", 32'(busyOut), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
